// File: rtl/vga_pkg.sv
// Shared timing defaults, pattern mode encoding and small helpers for the
// VGA test-pattern generator.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Counters are wide enough for any line or frame up to 2047 units.
    localparam int POS_W = 11;
    localparam int OFS_W = 10;

    typedef enum logic [1:0] {
        XOR      = 2'd0,
        CHECKER  = 2'd1,
        GRADIENT = 2'd2,
        SOLID    = 2'd3
    } mode_e;

    function automatic logic in_window(input logic [POS_W-1:0] pos, input int lo, input int hi);
        return (pos >= POS_W'(lo)) && (pos < POS_W'(hi));
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with combinational sync decode and a
// frame-boundary strobe on the last pixel of the last line.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0
)
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic h_last;
    logic v_last;

    assign h_last    = (hpos == POS_W'(H_TOTAL - 1));
    assign v_last    = (vpos == POS_W'(V_TOTAL - 1));
    assign frame_end = h_last && v_last;

    // The line counter only advances when the pixel counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos <= '0;
            vpos <= '0;
        end else if (h_last) begin
            hpos <= '0;
            vpos <= v_last ? '0 : vpos + POS_W'(1);
        end else begin
            hpos <= hpos + POS_W'(1);
        end
    end

    assign hsync = in_window(hpos, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vsync = in_window(vpos, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: per-frame mode/scroll registers, pattern
// colour logic and the registered output stage, driven by vga_timing.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int CB       = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode_i,
    input  logic [2:0]    speed_i,
    input  logic          freeze_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [CB-1:0] r_o,
    output logic [CB-1:0] g_o,
    output logic [CB-1:0] b_o,
    output logic          frame_o
);

    localparam logic [CB-1:0] ONES = '1;

    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vpos;
    logic             hsync;
    logic             vsync;
    logic             frame_end;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .hpos      (hpos),
        .vpos      (vpos),
        .hsync     (hsync),
        .vsync     (vsync),
        .frame_end (frame_end)
    );

    mode_e            mode_q;
    mode_e            mode_next;
    logic [2:0]       speed_q;
    logic [2:0]       speed_next;
    logic [OFS_W-1:0] offset_q;
    logic [OFS_W-1:0] offset_next;
    logic             boundary_q;

    // Pattern controls are only allowed to change on the last pixel of a frame.
    always_comb begin
        mode_next   = mode_q;
        speed_next  = speed_q;
        offset_next = offset_q;
        if (frame_end) begin
            mode_next  = mode_e'(mode_i);
            speed_next = speed_i;
            if (!freeze_i) begin
                offset_next = offset_q + OFS_W'(speed_next);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= XOR;
            speed_q    <= '0;
            offset_q   <= '0;
            boundary_q <= 1'b0;
        end else begin
            mode_q     <= mode_next;
            speed_q    <= speed_next;
            offset_q   <= offset_next;
            boundary_q <= frame_end;
        end
    end

    logic [OFS_W-1:0] x_pix;
    logic [OFS_W-1:0] y_pix;
    logic [OFS_W-1:0] xy_pix;
    logic             active;

    assign x_pix  = OFS_W'(hpos + POS_W'(offset_q));
    assign y_pix  = vpos[OFS_W-1:0];
    assign xy_pix = x_pix ^ y_pix;
    assign active = (hpos < POS_W'(H_ACTIVE)) && (vpos < POS_W'(V_ACTIVE));

    logic [CB-1:0] r_next;
    logic [CB-1:0] g_next;
    logic [CB-1:0] b_next;

    // Each channel takes the top CB bits of the slice named by the mode.
    always_comb begin
        r_next = '0;
        g_next = '0;
        b_next = '0;
        if (active) begin
            case (mode_q)
                XOR: begin
                    r_next = CB'(xy_pix >> (8 - CB));
                    g_next = CB'(x_pix >> (9 - CB));
                    b_next = CB'(y_pix >> (9 - CB));
                end
                CHECKER: begin
                    if (x_pix[5] ^ y_pix[5]) begin
                        r_next = ONES;
                        g_next = ONES;
                        b_next = ONES;
                    end
                end
                GRADIENT: begin
                    r_next = CB'(x_pix >> (10 - CB));
                    g_next = CB'(y_pix >> (9 - CB));
                    b_next = CB'(offset_q >> (10 - CB));
                end
                SOLID: begin
                    r_next = ONES;
                    g_next = ONES;
                    b_next = ONES;
                end
            endcase
        end
    end

    // One register stage keeps syncs, enable, colour and frame strobe aligned;
    // boundary_q is clear after reset, so the first post-reset frame does not pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_o <= ~SYNC_POL;
            vsync_o <= ~SYNC_POL;
            de_o    <= 1'b0;
            r_o     <= '0;
            g_o     <= '0;
            b_o     <= '0;
            frame_o <= 1'b0;
        end else begin
            hsync_o <= hsync;
            vsync_o <= vsync;
            de_o    <= active;
            r_o     <= r_next;
            g_o     <= g_next;
            b_o     <= b_next;
            frame_o <= boundary_q && (hpos == '0) && (vpos == '0);
        end
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter CB, default 2: colour bits per channel, legal 1..4.
REQ-002 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-004 SHALL have parameter SYNC_POL, default 0: sync active level (0 = active-low).
REQ-005 clk  in  1  pixel clock; single clock domain.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 mode_i  in  2  pattern select, sampled at frame boundary.
REQ-008 speed_i  in  3  scroll step per frame, sampled at frame boundary.
REQ-009 freeze_i  in  1  when high, holds the scroll offset at the frame boundary.
REQ-010 hsync_o, vsync_o  out  1 each  registered syncs at SYNC_POL.
REQ-011 de_o  out  1  registered display-enable.
REQ-012 r_o, g_o, b_o  out  CB each  registered colour.
REQ-013 frame_o  out  1  one-cycle pulse at first pixel of each frame.

Function
REQ-014 hpos SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params) and wrap; vpos SHALL increment on hpos wrap, 0..V_TOTAL-1, and wrap.
REQ-015 Sync SHALL be active when hpos is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); likewise vsync on vpos.
REQ-016 active = (hpos < H_ACTIVE) && (vpos < V_ACTIVE).
REQ-017 All outputs SHALL be registered with exactly one cycle latency from counter state; syncs, de_o and colour stay mutually aligned.
REQ-018 Frame boundary = cycle with hpos = H_TOTAL-1 and vpos = V_TOTAL-1.
REQ-019 At the boundary: mode_q <= mode_i; speed_q <= speed_i; offset (10 bits) <= offset + speed_i modulo 1024 unless freeze_i, else held.
REQ-020 mode_i/speed_i changes mid-frame SHALL have no effect until the next boundary.
REQ-021 frame_o SHALL be high only in the output cycle carrying pixel (0,0).
REQ-022 x' = (hpos + offset) mod 1024; y = vpos[9:0].
REQ-023 Mode 0 (XOR): r = (x' ^ y)[7:8-CB]; g = x'[8:9-CB]; b = y[8:9-CB].
REQ-024 Mode 1 (checker): all channels all-ones when x'[5] ^ y[5], else zero.
REQ-025 Mode 2 (gradient): r = x'[9:10-CB]; g = y[8:9-CB]; b = offset[9:10-CB].
REQ-026 Mode 3 (solid): all channels all-ones; offset ignored.
REQ-027 When active is low, colour outputs SHALL be zero regardless of mode.

Reset
REQ-028 On rst_n low, asynchronously: hpos = vpos = 0, offset = 0, mode_q = 0, speed_q = 0, de_o = 0, colours = 0, frame_o = 0, syncs at inactive level (~SYNC_POL).
REQ-029 Reset mid-frame SHALL abort the frame; the first cycle after release processes hpos = 0, vpos = 0. frame_o SHALL NOT pulse for that post-reset frame start.

Structure
REQ-030 Package vga_pkg SHALL hold the default timing constants, derived H_TOTAL/V_TOTAL, and the mode enum (XOR, CHECKER, GRADIENT, SOLID).
REQ-031 Counters and sync decode SHALL live in sub-module vga_timing. Pattern logic, frame registers and output registers stay in vga_pattern_gen.

Verification
REQ-032 Reset release with defaults -> hsync_o low in cycles 657..752 after release; vsync_o low for lines 490..491; de_o high 640 cycles per line.
REQ-033 mode_i = 3 held through a boundary -> next frame has r/g/b = 2'b11 while de_o = 1 and 2'b00 in blanking.
REQ-034 mode_i = 2, speed_i = 7, 37 boundaries -> offset = 259; r_o at pixel (0,0) = 2'b01; after 147 boundaries offset wraps to 5.
REQ-035 freeze_i high across a boundary with speed_i = 5 -> offset unchanged; mode_q still updates.
REQ-036 mode_i toggled 0 -> 1 at line 100 -> rest of frame stays mode 0; mode 1 from the next pixel (0,0); frame_o pulses once there.
REQ-037 rst_n pulsed low at line 200 -> outputs immediately at reset values; timing restarts at hpos = 0, vpos = 0.
